// File: rtl/mc_control_fsm_pkg.sv
// Shared types and encodings for the multicycle control FSM: state enum, ALUOp
// codes, opcode/funct values, mux selects and the per-state control word.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, R_EXEC, R_WB, I_EXEC, I_WB,
    MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, BRANCH, JUMP, ILLEGAL
  } state_e;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_ADDI = 4'b0001;
  localparam logic [3:0] ALU_SUB  = 4'b0010;
  localparam logic [3:0] ALU_AND  = 4'b0011;
  localparam logic [3:0] ALU_ANDI = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLT  = 4'b1001;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_SRA = 6'h03;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_RS    = 2'b01;
  localparam logic [1:0] SRCA_SHAMT = 2'b10;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_S2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [1:0] {SEL_R, SEL_ADDI, SEL_ANDI} alu_sel_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_cond;
    logic [1:0] pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       illegal;
  } ctrl_t;

  // Moore control word for a state; the FETCH strobes are gated by mem_ready later.
  function automatic ctrl_t state_ctrl(input state_e st, input logic [3:0] dec_op,
                                       input logic dec_shift);
    ctrl_t c;
    c = '0;
    case (st)
      FETCH: begin
        c.mem_read  = 1'b1;
        c.ir_write  = 1'b1;
        c.pc_write  = 1'b1;
        c.alu_src_a = SRCA_PC;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALU_ADD;
        c.pc_source = PCSRC_ALU;
      end
      DECODE: begin
        c.alu_src_a = SRCA_PC;
        c.alu_src_b = SRCB_IMM_S2;
        c.alu_op    = ALU_ADD;
      end
      R_EXEC: begin
        c.alu_src_a = dec_shift ? SRCA_SHAMT : SRCA_RS;
        c.alu_src_b = SRCB_RT;
        c.alu_op    = dec_op;
      end
      R_WB: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
      end
      I_EXEC: begin
        c.alu_src_a = SRCA_RS;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = dec_op;
      end
      I_WB:     c.reg_write = 1'b1;
      MEM_ADDR: begin
        c.alu_src_a = SRCA_RS;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALU_ADD;
      end
      MEM_READ: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      MEM_WB: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
      end
      MEM_WRITE: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      BRANCH: begin
        c.alu_src_a = SRCA_RS;
        c.alu_src_b = SRCB_RT;
        c.alu_op    = ALU_SUB;
        c.pc_source = PCSRC_ALUOUT;
        c.pc_cond   = 1'b1;
      end
      JUMP: begin
        c.pc_source = PCSRC_JUMP;
        c.pc_write  = 1'b1;
      end
      ILLEGAL: c.illegal = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Controller <-> datapath bundle: IR fields and status in, control strobes out.
interface mc_control_fsm_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pc_en;
  logic [1:0] pc_source;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [3:0] alu_op;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       illegal;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_en, pc_source, iord, mem_read, mem_write, ir_write,
           alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write, illegal
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_en, pc_source, iord, mem_read, mem_write, ir_write,
           alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write, illegal
  );
endinterface

// File: rtl/mc_control_fsm_alu_op_decoder.sv
// Maps an R-type funct (or an I-type selector) to the ALUOp code and flags
// whether the op is a shift and whether the funct is supported.
module alu_op_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  input  alu_sel_e   sel,
  output logic [3:0] alu_op,
  output logic       is_shift,
  output logic       funct_valid
);

  always_comb begin
    alu_op      = ALU_ADD;
    is_shift    = 1'b0;
    funct_valid = 1'b1;
    case (sel)
      SEL_ADDI: alu_op = ALU_ADDI;
      SEL_ANDI: alu_op = ALU_ANDI;
      default: begin
        case (funct)
          FN_ADD: alu_op = ALU_ADD;
          FN_SUB: alu_op = ALU_SUB;
          FN_AND: alu_op = ALU_AND;
          FN_OR:  alu_op = ALU_OR;
          FN_SLT: alu_op = ALU_SLT;
          FN_SLL: begin alu_op = ALU_SLL; is_shift = 1'b1; end
          FN_SRL: begin alu_op = ALU_SRL; is_shift = 1'b1; end
          FN_SRA: begin alu_op = ALU_SRA; is_shift = 1'b1; end
          default: funct_valid = 1'b0;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle control FSM: sequences FETCH/DECODE/EXECUTE/MEM/WB with registered
// Moore outputs and counts retired instructions.
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  mc_control_fsm_if.master    bus,
  output logic [RETIRE_W-1:0] retired
);

  state_e   state, nxt;
  ctrl_t    c;
  alu_sel_e sel;
  logic [3:0] dec_op;
  logic       dec_shift, dec_valid, retire;

  always_comb begin
    sel = SEL_R;
    if (bus.opcode == OP_ADDI)      sel = SEL_ADDI;
    else if (bus.opcode == OP_ANDI) sel = SEL_ANDI;
  end

  alu_op_decoder u_dec (
    .funct       (bus.funct),
    .sel         (sel),
    .alu_op      (dec_op),
    .is_shift    (dec_shift),
    .funct_valid (dec_valid)
  );

  always_comb begin
    nxt = state;
    case (state)
      IDLE:   nxt = FETCH;
      FETCH:  if (bus.mem_ready) nxt = DECODE;
      DECODE: begin
        case (bus.opcode)
          OP_RTYPE:        nxt = dec_valid ? R_EXEC : ILLEGAL;
          OP_ADDI, OP_ANDI: nxt = I_EXEC;
          OP_LW, OP_SW:    nxt = MEM_ADDR;
          OP_BEQ:          nxt = BRANCH;
          OP_J:            nxt = JUMP;
          default:         nxt = ILLEGAL;
        endcase
      end
      R_EXEC:    nxt = R_WB;
      I_EXEC:    nxt = I_WB;
      MEM_ADDR:  nxt = (bus.opcode == OP_LW) ? MEM_READ : MEM_WRITE;
      MEM_READ:  if (bus.mem_ready) nxt = MEM_WB;
      MEM_WRITE: if (bus.mem_ready) nxt = FETCH;
      R_WB, I_WB, MEM_WB, BRANCH, JUMP, ILLEGAL: nxt = FETCH;
      default:   nxt = IDLE;
    endcase
  end

  always_comb begin
    retire = 1'b0;
    case (state)
      R_WB, I_WB, MEM_WB, BRANCH, JUMP: retire = 1'b1;
      MEM_WRITE: retire = bus.mem_ready;
      default:   retire = 1'b0;
    endcase
  end

  // Control word is computed from the next state so outputs come straight off flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      c       <= '0;
      retired <= '0;
    end else begin
      state <= nxt;
      c     <= state_ctrl(nxt, dec_op, dec_shift);
      if (retire) retired <= retired + 1'b1;
    end
  end

  // ir_write is only set in FETCH, so it doubles as the "gate PCWrite by mem_ready" flag.
  assign bus.pc_en      = (c.pc_write & (bus.mem_ready | ~c.ir_write)) | (c.pc_cond & bus.zero);
  assign bus.ir_write   = c.ir_write & bus.mem_ready;
  assign bus.pc_source  = c.pc_source;
  assign bus.iord       = c.iord;
  assign bus.mem_read   = c.mem_read;
  assign bus.mem_write  = c.mem_write;
  assign bus.alu_src_a  = c.alu_src_a;
  assign bus.alu_src_b  = c.alu_src_b;
  assign bus.alu_op     = c.alu_op;
  assign bus.reg_dst    = c.reg_dst;
  assign bus.mem_to_reg = c.mem_to_reg;
  assign bus.reg_write  = c.reg_write;
  assign bus.illegal    = c.illegal;

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multicycle control unit that drives the ALU, its operand muxes and the datapath enables. It sits between the instruction register and the datapath.
- Decodes opcode/funct and sequences FETCH / DECODE / EXECUTE / MEM / WB, stalling on a memory ready handshake.
- Generates the 4-bit ALUOp consumed by the ALU: ADD 0000, ADDI 0001, SUB 0010, AND 0011, ANDI 0100, OR 0101, SLL 0110, SRL 0111, SRA 1000, SLT 1001.

Parameters:
- RETIRE_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  6  IR[31:26]; stable from DECODE onward.
- funct  in  6  IR[5:0].
- zero  in  1  ALU result == 0, computed in the datapath.
- mem_ready  in  1  memory has completed the current read or write this cycle.
- pc_en  out  1  PC load = PCWrite | (PCWriteCond & zero).
- pc_source  out  2  00 ALU result, 01 ALUOut register, 10 jump target.
- iord  out  1  memory address select: 0 PC, 1 ALUOut.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  IR load enable.
- alu_src_a  out  2  00 PC, 01 rs, 10 shamt (zero-extended).
- alu_src_b  out  2  00 rt, 01 constant 4, 10 sign-extended imm, 11 sign-extended imm << 2.
- alu_op  out  4  ALU operation, encoded as in the Overview.
- reg_dst  out  1  write register select: 0 rt, 1 rd.
- mem_to_reg  out  1  write data select: 0 ALUOut, 1 MDR.
- reg_write  out  1  register file write enable.
- illegal  out  1  one-cycle pulse on an unsupported opcode/funct.
- retired  out  RETIRE_W  count of completed instructions.

Behaviour:
- rst_n low (async): state <= IDLE, retired <= 0. All outputs are 0 in IDLE. IDLE -> FETCH unconditionally on the next edge.
- Outputs are Moore, decoded from state. Exceptions: ir_write and the PCWrite term of pc_en in FETCH are gated by mem_ready.
- FETCH: mem_read=1, iord=0, alu_src_a=00, alu_src_b=01, alu_op=ADD, pc_source=00.
  - mem_ready=0: stay in FETCH; ir_write=0, pc_en=0.
  - mem_ready=1: ir_write=1, pc_en=1, go to DECODE.
- DECODE: alu_src_a=00, alu_src_b=11, alu_op=ADD; this latches the branch target in ALUOut. Dispatch on opcode:
  - 000000 -> R_EXEC if funct is one of 0x20,0x22,0x24,0x25,0x2A,0x00,0x02,0x03; otherwise ILLEGAL.
  - 0x08 (addi), 0x0C (andi) -> I_EXEC.
  - 0x23 (lw), 0x2B (sw) -> MEM_ADDR.
  - 0x04 (beq) -> BRANCH.
  - 0x02 (j) -> JUMP.
  - any other opcode -> ILLEGAL.
- R_EXEC: alu_op from funct: add->ADD, sub->SUB, and->AND, or->OR, slt->SLT, sll->SLL, srl->SRL, sra->SRA.
  - Shifts: alu_src_a=10, alu_src_b=00. All others: alu_src_a=01, alu_src_b=00.
  - Next state R_WB.
- R_WB: reg_dst=1, mem_to_reg=0, reg_write=1 -> FETCH.
- I_EXEC: alu_src_a=01, alu_src_b=10, alu_op=ADDI for addi, ANDI for andi -> I_WB.
- I_WB: reg_dst=0, mem_to_reg=0, reg_write=1 -> FETCH.
- MEM_ADDR: alu_src_a=01, alu_src_b=10, alu_op=ADD -> MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: mem_read=1, iord=1. Hold until mem_ready=1, then go to MEM_WB.
- MEM_WB: reg_dst=0, mem_to_reg=1, reg_write=1 -> FETCH.
- MEM_WRITE: mem_write=1, iord=1. Hold until mem_ready=1, then go to FETCH.
- BRANCH: alu_src_a=01, alu_src_b=00, alu_op=SUB, pc_source=01. pc_en=zero. -> FETCH.
- JUMP: pc_source=10, pc_en=1 -> FETCH.
- ILLEGAL: illegal=1 for exactly one cycle, no writes -> FETCH. The PC has already advanced, so the instruction is skipped.
- retired increments by 1 on the edge leaving R_WB, I_WB, MEM_WB, BRANCH or JUMP, and on the edge leaving MEM_WRITE with mem_ready=1.
  - No increment from ILLEGAL.
  - Wraps from all-ones to 0.
- mem_read and mem_write are never both 1. reg_write and mem_write are never both 1.
- Reset asserted mid-instruction aborts immediately; no partial write is issued after reset.
- Latency with mem_ready tied to 1: R-type/addi/andi 4 cycles, lw 5, sw 4, beq 3, j 3.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state enum: IDLE, FETCH, DECODE, R_EXEC, R_WB, I_EXEC, I_WB, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, BRANCH, JUMP, ILLEGAL;
  - ALUOp localparams;
  - opcode and funct localparams;
  - mux-select encodings.
- One combinational sub-module, alu_op_decoder. Inputs: funct, an I-type selector. Outputs: alu_op, is_shift, funct_valid.

Test Plan:
- Reset, then mem_ready=1 with add ($rd=rd): IDLE 1 cycle; FETCH has mem_read=1, ir_write=1, pc_en=1; R_EXEC has alu_op=0000, alu_src_a=01; R_WB has reg_write=1, reg_dst=1; retired=1 after 5 edges.
- sll (funct 0x00): R_EXEC drives alu_op=0110, alu_src_a=10, alu_src_b=00.
- lw with mem_ready held 0 for 3 cycles in MEM_READ: state holds, mem_read=1 and iord=1 throughout. MEM_WB follows with mem_to_reg=1. Instruction takes 8 cycles.
- beq, once with zero=1 and once with zero=0: BRANCH has alu_op=0010, pc_source=01, and pc_en=1 or 0 respectively. retired increments in both cases.
- opcode 0x3F and R-type funct 0x18: illegal pulses for one cycle, reg_write/mem_write stay 0, retired unchanged, next state FETCH.
- rst_n dropped while in MEM_WRITE: outputs go to 0 asynchronously, retired=0, and the sequence restarts at IDLE -> FETCH.
